fp_unit_arbiter: RTL and testbench

- Shares the single combinational FP add/multiply datapath (`fp`) between NREQ requesters, e.g. execute-stage FP issue and a vector/coprocessor port.
- Registers the granted operands and holds them on the datapath for LATENCY cycles, which makes `fp` a multicycle path.
- Captures the result and returns it to the owning requester over a valid/ready handshake.
- Arbitration is round-robin, so no requester starves.

---
 rtl/fp_ctrl_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/fp_unit_arbiter.sv | 128 ++++++++++++
 tb/tb_fp_unit_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fp_ctrl_pkg.sv
// Shared definitions for the FP datapath sharing controller.
//   state_t   : controller FSM states
//   FP_OP_*   : ALUControl encoding of the shared `fp` datapath
//   FP_W      : operand/result width (IEEE-754 single)
package fp_ctrl_pkg;

  localparam int unsigned FP_W = 32;

  localparam logic FP_OP_ADD = 1'b0;
  localparam logic FP_OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : index of the highest-priority requester
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : index of the granted requester
//   any       : at least one request present
module rr_arbiter #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  int unsigned j;

  // Scan ptr, ptr+1, ... modulo NREQ; the first requester found wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = (32'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any       = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Shares one combinational FP add/multiply datapath between NREQ requesters.
// The granted operands are registered and held on the datapath for LATENCY
// cycles (multicycle path), then the result is captured and returned to the
// owner over a valid/ready handshake. Arbitration is round-robin.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester request handshake (one-hot ready)
//   req_a/req_b/req_op    : per-requester operands, 32-bit slices
//   resp_valid/resp_ready : per-requester response handshake (one-hot valid)
//   resp_result           : shared result, qualified by resp_valid
//   fp_a/fp_b/fp_op       : registered operands driven to `fp`
//   fp_result             : `fp` result
//   busy                  : controller not idle
module fp_unit_arbiter
  import fp_ctrl_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [FP_W*NREQ-1:0] req_a,
  input  logic [FP_W*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]      req_op,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [FP_W-1:0]      resp_result,
  output logic [FP_W-1:0]      fp_a,
  output logic [FP_W-1:0]      fp_b,
  output logic                 fp_op,
  input  logic [FP_W-1:0]      fp_result,
  output logic                 busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q;
  logic [IW-1:0]     owner_q;
  logic [CW-1:0]     cnt_q;
  logic [FP_W-1:0]   fp_a_q, fp_b_q, res_q;
  logic              fp_op_q;

  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     grant_idx;
  logic              grant_any;
  logic              accept;
  logic              done;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    resp_valid = '0;
    accept     = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (grant_any) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) state_d = RESP;
      end
      RESP: begin
        resp_valid[owner_q] = 1'b1;
        if (resp_ready[owner_q]) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset dominates the handshake outputs in the cycle it is asserted.
    if (reset) begin
      req_ready  = '0;
      resp_valid = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      fp_a_q   <= '0;
      fp_b_q   <= '0;
      fp_op_q  <= FP_OP_ADD;
      res_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        fp_a_q  <= req_a[grant_idx*FP_W +: FP_W];
        fp_b_q  <= req_b[grant_idx*FP_W +: FP_W];
        fp_op_q <= req_op[grant_idx];
        owner_q <= grant_idx;
        cnt_q   <= CW'(LATENCY - 1);
      end
      if (state_q == EXEC) begin
        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        else             res_q <= fp_result;
      end
      if (done) begin
        rr_ptr_q <= (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
      end
    end
  end

  assign fp_a        = fp_a_q;
  assign fp_b        = fp_b_q;
  assign fp_op       = fp_op_q;
  assign resp_result = res_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_fp_unit_arbiter.sv
module tb_fp_unit_arbiter;
  import fp_ctrl_pkg::*;

  localparam int unsigned NREQ = 3;
  localparam int unsigned LAT  = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_op;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready;
  logic [31:0]          resp_result;
  logic [31:0]          fp_a;
  logic [31:0]          fp_b;
  logic                 fp_op;
  logic [31:0]          fp_result;
  logic                 busy;

  int checks = 0;
  int errors = 0;

  fp_unit_arbiter #(.NREQ(NREQ), .LATENCY(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_op      (req_op),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .fp_a        (fp_a),
    .fp_b        (fp_b),
    .fp_op       (fp_op),
    .fp_result   (fp_result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Stub datapath: the correct value only appears once operands have been
  // stable for LAT cycles; before that it presents 0xDEADBEEF.
  function automatic logic [31:0] stub_good(logic [31:0] a, logic [31:0] b, logic op);
    return (op == FP_OP_MUL) ? a + b : a ^ b;
  endfunction

  int unsigned age  = 0;
  logic [64:0] prev = '1;

  always @(negedge clk) begin
    if ({fp_a, fp_b, fp_op} != prev) begin
      prev <= {fp_a, fp_b, fp_op};
      age  <= 1;
    end else if (age < 1000) begin
      age <= age + 1;
    end
  end

  assign fp_result = (age >= LAT) ? stub_good(fp_a, fp_b, fp_op) : 32'hDEADBEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference: at most one job in flight, identified by
  // owner, accept cycle and expected result.
  bit          has_job = 0;
  int          m_owner = 0;
  int          m_acc   = 0;
  logic [31:0] m_res   = '0;
  int          rr_next = 0;
  logic [31:0] last_a  = '0;
  logic [31:0] last_b  = '0;
  logic        last_op = 1'b0;
  int          cyc     = 0;
  int          grants[NREQ];

  task automatic run_cycle(input int vprob, input int rprob, input bit do_reset);
    logic [NREQ-1:0] exp_grant;
    logic [NREQ-1:0] exp_rv;
    int              g_idx;
    bit              in_resp;
    @(posedge clk);
    #1;
    reset = do_reset;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = ($urandom_range(99) < vprob);
      req_a[i*32 +: 32]    = $urandom;
      req_b[i*32 +: 32]    = $urandom;
      req_op[i]            = $urandom_range(1);
      resp_ready[i]        = ($urandom_range(99) < rprob);
    end
    @(negedge clk);
    exp_grant = '0;
    g_idx     = 0;
    if (!has_job && !reset) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (rr_next + k) % NREQ;
        if (exp_grant == '0 && req_valid[j]) begin
          exp_grant[j] = 1'b1;
          g_idx        = j;
        end
      end
    end
    in_resp = has_job && (cyc >= m_acc + LAT + 1);
    exp_rv  = (in_resp && !reset) ? NREQ'(1) << m_owner : '0;

    check("req_ready", 32'(req_ready), 32'(exp_grant));
    check("resp_valid", 32'(resp_valid), 32'(exp_rv));
    if (!reset) check("busy", 32'(busy), 32'(has_job));
    check("fp_a", fp_a, last_a);
    check("fp_b", fp_b, last_b);
    check("fp_op", 32'(fp_op), 32'(last_op));
    if (exp_rv != '0) begin
      check("resp_result", resp_result, m_res);
      check("no_early_sample", 32'(resp_result == 32'hDEADBEEF), 32'd0);
    end

    if (reset) begin
      has_job = 0;
      rr_next = 0;
      last_a  = '0;
      last_b  = '0;
      last_op = 1'b0;
    end else if (exp_grant != '0) begin
      has_job = 1;
      m_owner = g_idx;
      m_acc   = cyc;
      last_a  = req_a[g_idx*32 +: 32];
      last_b  = req_b[g_idx*32 +: 32];
      last_op = req_op[g_idx];
      m_res   = stub_good(last_a, last_b, last_op);
      grants[g_idx]++;
    end else if (in_resp && resp_ready[m_owner]) begin
      has_job = 0;
      rr_next = (m_owner + 1) % NREQ;
    end
    cyc++;
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = '0;
    foreach (grants[i]) grants[i] = 0;

    // Reset state
    run_cycle(0, 0, 1'b1);
    run_cycle(0, 0, 1'b1);
    // Full contention, responses accepted immediately: strict rotation
    repeat (60)  run_cycle(100, 100, 1'b0);
    // Heavy back-pressure with all requesters contending
    repeat (120) run_cycle(100, 15, 1'b0);
    // Sparse random traffic
    repeat (300) run_cycle(40, 60, 1'b0);
    // Random traffic with occasional resets, including mid-operation
    repeat (400) run_cycle(60, 50, ($urandom_range(99) < 4));
    // Reset then full contention: rotation restarts at requester 0
    run_cycle(100, 100, 1'b1);
    repeat (30)  run_cycle(100, 100, 1'b0);

    for (int i = 0; i < NREQ; i++) check("granted_at_least_once", 32'(grants[i] > 0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
